// File: rtl/mmcm_drp_pkg.sv
// Shared types and constants for the MMCM DRP sequencer.
package mmcm_drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  localparam int DEF_RST_HOLD     = 8;
  localparam int DEF_DRDY_TIMEOUT = 64;
  localparam int DEF_LOCK_TIMEOUT = 65535;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RD_REQ    = 4'd1,
    ST_RD_WAIT   = 4'd2,
    ST_WR_RST    = 4'd3,
    ST_WR_REQ    = 4'd4,
    ST_WR_WAIT   = 4'd5,
    ST_RST_HOLD  = 4'd6,
    ST_LOCK_WAIT = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  // States during which the MMCM is held in reset for a write.
  function automatic logic is_rst_phase(input state_e s);
    logic v;
    case (s)
      ST_WR_RST, ST_WR_REQ, ST_WR_WAIT, ST_RST_HOLD: v = 1'b1;
      default:                                        v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mmcm_drp_ctrl_sync_ff.sv
// Two-flop synchronizer for the asynchronous MMCM LOCKED input.
module sync_ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the async input through two flops; reset clears both to 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// DRP sequencer: single register read/write, with writes wrapped in an
// MMCM reset and lock-reacquire sequence. Every accepted request ends in
// exactly one cfg_rdy pulse, including timed-out ones.
module mmcm_drp_ctrl
  import mmcm_drp_pkg::*;
#(
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int DRDY_TIMEOUT = DEF_DRDY_TIMEOUT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_ena,
  input  logic              i_cfg_wen,
  input  logic [DRP_AW-1:0] i_cfg_addr,
  input  logic [31:0]       i_cfg_wdata,
  output logic [31:0]       o_cfg_rdata,
  output logic              o_cfg_rdy,
  output logic              o_drp_den,
  output logic              o_drp_dwe,
  output logic [DRP_AW-1:0] o_drp_daddr,
  output logic [DRP_DW-1:0] o_drp_di,
  input  logic [DRP_DW-1:0] i_drp_do,
  input  logic              i_drp_drdy,
  output logic              o_mmcm_rst,
  input  logic              i_mmcm_locked,
  output logic              o_busy,
  output logic              o_err
);

  // Counter starts at 0 in the entry cycle, so "last" is limit-1.
  localparam logic [15:0] C_DRDY_LAST = 16'(DRDY_TIMEOUT - 1);
  localparam logic [15:0] C_HOLD_LAST = 16'(RST_HOLD - 1);
  localparam logic [15:0] C_LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [15:0]         r_cnt;
  logic [DRP_AW-1:0]   r_addr;
  logic [DRP_DW-1:0]   r_wdata;
  logic [DRP_DW-1:0]   r_rdata;
  logic                r_den;
  logic                r_dwe;
  logic                r_mmcm_rst;
  logic                r_busy;
  logic                r_rdy;
  logic                r_err;
  logic                w_locked;
  logic                w_accept;
  logic                w_set_err;
  logic                w_ld_rdata;
  logic [DRP_DW-1:0]   w_rdata_nxt;
  logic                w_unused;

  // Upper write-data half is not part of the DRP word.
  assign w_unused = &{1'b0, i_cfg_wdata[31:16]};

  sync_ff u_lock_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_mmcm_locked),
    .o_q     (w_locked)
  );

  // Next-state and side-effect decode; DRDY wins over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_set_err   = 1'b0;
    w_ld_rdata  = 1'b0;
    w_rdata_nxt = {DRP_DW{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (i_cfg_ena) begin
          w_accept = 1'b1;
          if (i_cfg_wen) begin
            w_state_nxt = ST_WR_RST;
          end else begin
            w_state_nxt = ST_RD_REQ;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (i_drp_drdy) begin
          w_state_nxt = ST_DONE;
          w_ld_rdata  = 1'b1;
          w_rdata_nxt = i_drp_do;
        end else if (r_cnt == C_DRDY_LAST) begin
          w_state_nxt = ST_DONE;
          w_ld_rdata  = 1'b1;
          w_set_err   = 1'b1;
        end else begin
          w_state_nxt = ST_RD_WAIT;
        end
      end
      ST_WR_RST: w_state_nxt = ST_WR_REQ;
      ST_WR_REQ: w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (i_drp_drdy) begin
          w_state_nxt = ST_RST_HOLD;
        end else if (r_cnt == C_DRDY_LAST) begin
          w_state_nxt = ST_RST_HOLD;
          w_set_err   = 1'b1;
        end else begin
          w_state_nxt = ST_WR_WAIT;
        end
      end
      ST_RST_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = ST_LOCK_WAIT;
        end else begin
          w_state_nxt = ST_RST_HOLD;
        end
      end
      ST_LOCK_WAIT: begin
        if (w_locked) begin
          w_state_nxt = ST_DONE;
        end else if (r_cnt == C_LOCK_LAST) begin
          w_state_nxt = ST_DONE;
          w_set_err   = 1'b1;
        end else begin
          w_state_nxt = ST_LOCK_WAIT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and per-state saturating cycle counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= 16'd0;
      end else if (r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Registered outputs decoded from the next state, plus request latches.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;
      r_mmcm_rst <= 1'b0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= {DRP_AW{1'b0}};
      r_wdata    <= {DRP_DW{1'b0}};
      r_rdata    <= {DRP_DW{1'b0}};
    end else begin
      r_den      <= (w_state_nxt == ST_RD_REQ) || (w_state_nxt == ST_WR_REQ);
      r_dwe      <= (w_state_nxt == ST_WR_REQ);
      r_mmcm_rst <= is_rst_phase(w_state_nxt);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_rdy      <= (w_state_nxt == ST_DONE);
      if (w_set_err) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_addr  <= i_cfg_addr;
        r_wdata <= i_cfg_wdata[DRP_DW-1:0];
      end
      if (w_ld_rdata) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

  assign o_cfg_rdata = {{(32-DRP_DW){1'b0}}, r_rdata};
  assign o_cfg_rdy   = r_rdy;
  assign o_drp_den   = r_den;
  assign o_drp_dwe   = r_dwe;
  assign o_drp_daddr = r_addr;
  assign o_drp_di    = r_wdata;
  assign o_mmcm_rst  = r_mmcm_rst;
  assign o_busy      = r_busy;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Scoreboard bench for mmcm_drp_ctrl with DRP slave and MMCM lock models.
module tb_mmcm_drp_ctrl;

  localparam int P_RST_HOLD = 8;
  localparam int P_DRDY_TMO = 64;
  localparam int P_LOCK_TMO = 100;
  localparam int P_LOCK_DLY = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_ena = 1'b0;
  logic        cfg_wen = 1'b0;
  logic [6:0]  cfg_addr = 7'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        cfg_rdy;
  logic        drp_den, drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic        mmcm_rst;
  logic        mmcm_locked = 1'b1;
  logic        busy, err;

  mmcm_drp_ctrl #(
    .RST_HOLD     (P_RST_HOLD),
    .DRDY_TIMEOUT (P_DRDY_TMO),
    .LOCK_TIMEOUT (P_LOCK_TMO)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_cfg_ena (cfg_ena), .i_cfg_wen (cfg_wen), .i_cfg_addr (cfg_addr),
    .i_cfg_wdata (cfg_wdata), .o_cfg_rdata (cfg_rdata), .o_cfg_rdy (cfg_rdy),
    .o_drp_den (drp_den), .o_drp_dwe (drp_dwe), .o_drp_daddr (drp_daddr),
    .o_drp_di (drp_di), .i_drp_do (drp_do), .i_drp_drdy (drp_drdy),
    .o_mmcm_rst (mmcm_rst), .i_mmcm_locked (mmcm_locked),
    .o_busy (busy), .o_err (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- DRP slave model ----------------
  function automatic logic [15:0] drp_data(input logic [6:0] a);
    logic [15:0] v;
    if (a == 7'h14) v = 16'hA5C3;
    else            v = {~a, 2'b01, a};
    return v;
  endfunction

  int         drp_lat = 3;
  logic       drp_resp_en = 1'b1;
  int         drp_cnt = 0;
  logic       drp_pend = 1'b0;
  logic [6:0] drp_addr_q = 7'd0;

  // DRDY arrives drp_lat cycles after the DEN cycle.
  always @(posedge clk) begin
    drp_drdy <= 1'b0;
    if (drp_den) begin
      drp_addr_q <= drp_daddr;
      drp_cnt    <= drp_lat - 1;
      drp_pend   <= drp_resp_en;
    end else if (drp_pend) begin
      if (drp_cnt <= 1) begin
        drp_drdy <= 1'b1;
        drp_do   <= drp_data(drp_addr_q);
        drp_pend <= 1'b0;
      end else begin
        drp_cnt <= drp_cnt - 1;
      end
    end
  end

  // ---------------- MMCM lock model ----------------
  logic lock_en = 1'b1;
  int   lock_cnt = 0;

  // LOCKED drops under reset and returns P_LOCK_DLY cycles after release.
  always @(posedge clk) begin
    if (mmcm_rst) begin
      mmcm_locked <= 1'b0;
      lock_cnt    <= 0;
    end else if (lock_en && !mmcm_locked) begin
      if (lock_cnt >= P_LOCK_DLY - 1) mmcm_locked <= 1'b1;
      lock_cnt <= lock_cnt + 1;
    end
  end

  // ---------------- Scoreboard and monitor ----------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          start;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int         rdy_cnt = 0, rdy_cyc = 0;
  int         den_cycles = 0, den_cyc = 0;
  logic [6:0] den_addr = 7'd0;
  logic       den_dwe = 1'b0;
  logic [15:0] den_di = 16'd0;
  int         rst_rise_cyc = 0, rst_fall_cyc = 0, rst_high = 0, rst_after_drdy = 0;
  int         lock_rise_cyc = 0;
  logic       prev_rst = 1'b0, prev_lock = 1'b1, post_drdy = 1'b0;

  always @(negedge clk) begin
    prev_rst  <= mmcm_rst;
    prev_lock <= mmcm_locked;
    if (drp_den) begin
      den_cycles <= den_cycles + 1;
      den_addr   <= drp_daddr;
      den_dwe    <= drp_dwe;
      den_di     <= drp_di;
      den_cyc    <= cyc;
    end
    if (mmcm_rst && !prev_rst) rst_rise_cyc <= cyc;
    if (!mmcm_rst && prev_rst) rst_fall_cyc <= cyc;
    if (mmcm_rst) rst_high <= rst_high + 1;
    if (mmcm_rst && post_drdy) rst_after_drdy <= rst_after_drdy + 1;
    if (!mmcm_rst) post_drdy <= 1'b0;
    else if (drp_drdy) post_drdy <= 1'b1;
    if (mmcm_locked && !prev_lock) lock_rise_cyc <= cyc;
    if (cfg_rdy) begin
      rdy_cnt <= rdy_cnt + 1;
      rdy_cyc <= cyc;
      if (sb.size() == 0) begin
        check_val("spurious_rdy", 32'd1, 32'd0);
      end else begin
        check_val("rdata", cfg_rdata, sb[0].rdata);
        check_val("err_at_rdy", 32'(err), 32'(sb[0].err));
        if (sb[0].lat > 0) check_val("latency", 32'(cyc - sb[0].start), 32'(sb[0].lat));
        void'(sb.pop_front());
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  logic [31:0] exp_last_rd = 32'd0;
  logic        exp_err = 1'b0;
  int          req_start = 0;

  task automatic do_req(input logic wen, input logic [6:0] addr, input logic [31:0] wd,
                        input int lat, input logic [31:0] exp_rd, input logic fails);
    int k;
    k = 0;
    while (busy && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    cfg_ena = 1'b1; cfg_wen = wen; cfg_addr = addr; cfg_wdata = wd;
    if (fails) exp_err = 1'b1;
    if (!wen) exp_last_rd = exp_rd;
    req_start = cyc;
    sb.push_back('{exp_last_rd, exp_err, cyc, lat});
    @(posedge clk); #1;
    cfg_ena = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk); #1; k++;
    end
    if (sb.size() != 0) begin
      check_val("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    exp_err = 1'b0;
    exp_last_rd = 32'd0;
  endtask

  int rdy0, den0, rh0, ra0, k;

  initial begin
    // Reset values
    apply_reset();
    check_val("rst_rdata", cfg_rdata, 32'd0);
    check_val("rst_rdy", 32'(cfg_rdy), 32'd0);
    check_val("rst_den", 32'(drp_den), 32'd0);
    check_val("rst_dwe", 32'(drp_dwe), 32'd0);
    check_val("rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read 0x14, DRDY three cycles after DEN
    drp_lat = 3; rdy0 = rdy_cnt; den0 = den_cycles;
    do_req(1'b0, 7'h14, 32'd0, 5, 32'h0000A5C3, 1'b0);
    wait_done(200);
    check_val("rd_den_cycles", 32'(den_cycles - den0), 32'd1);
    check_val("rd_daddr", 32'(den_addr), 32'h14);
    check_val("rd_dwe", 32'(den_dwe), 32'd0);
    check_val("rd_rdy_count", 32'(rdy_cnt - rdy0), 32'd1);

    // Write 0x08 <- 0xDEAD1234, lock returns 20 cycles after release
    drp_lat = 4; rdy0 = rdy_cnt; den0 = den_cycles; rh0 = rst_high; ra0 = rst_after_drdy;
    do_req(1'b1, 7'h08, 32'hDEAD1234, 0, 32'd0, 1'b0);
    wait_done(500);
    check_val("wr_den_cycles", 32'(den_cycles - den0), 32'd1);
    check_val("wr_dwe", 32'(den_dwe), 32'd1);
    check_val("wr_di", 32'(den_di), 32'h1234);
    check_val("wr_daddr", 32'(den_addr), 32'h08);
    check_val("wr_rst_rise", 32'(rst_rise_cyc - req_start), 32'd1);
    check_val("wr_rst_before_den", 32'(den_cyc - rst_rise_cyc), 32'd1);
    check_val("wr_rst_len_min", 32'((rst_high - rh0) >= P_RST_HOLD + 1), 32'd1);
    check_val("wr_rst_after_drdy", 32'(rst_after_drdy - ra0), 32'(P_RST_HOLD));
    check_val("wr_rdy_after_lock", 32'(rdy_cyc - lock_rise_cyc), 32'd3);
    check_val("wr_rdy_count", 32'(rdy_cnt - rdy0), 32'd1);

    // Strobes while busy are ignored
    drp_lat = 6; rdy0 = rdy_cnt;
    do_req(1'b0, 7'h05, 32'd0, 8, {16'h0, drp_data(7'h05)}, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cfg_ena = 1'b1; cfg_wen = 1'(i % 2); cfg_addr = 7'h7F;
      @(posedge clk); #1;
      cfg_ena = 1'b0;
      @(posedge clk); #1;
    end
    wait_done(200);
    repeat (30) @(posedge clk);
    #1;
    check_val("busy_strobe_rdy_count", 32'(rdy_cnt - rdy0), 32'd1);
    check_val("busy_strobe_idle", 32'(busy), 32'd0);

    // 16 back-to-back reads with varying DRDY latency
    rdy0 = rdy_cnt;
    for (int i = 0; i < 16; i++) begin
      logic [6:0] a;
      a = 7'(i * 5 + 1);
      drp_lat = 2 + (i % 4);
      do_req(1'b0, a, 32'd0, drp_lat + 2, {16'h0, drp_data(a)}, 1'b0);
      wait_done(200);
    end
    check_val("b2b_rdy_count", 32'(rdy_cnt - rdy0), 32'd16);

    // Reset in the middle of RST_HOLD
    drp_lat = 3; rdy0 = rdy_cnt;
    do_req(1'b1, 7'h10, 32'h0000BEEF, 0, 32'd0, 1'b0);
    k = 0;
    while (!drp_drdy && k < 200) begin
      @(posedge clk); #1; k++;
    end
    check_val("wr_drdy_seen", 32'(drp_drdy), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    exp_last_rd = 32'd0;
    @(posedge clk); #1;
    check_val("mid_rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_rdata", cfg_rdata, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_val("mid_rst_no_rdy", 32'(rdy_cnt - rdy0), 32'd0);
    do_req(1'b0, 7'h33, 32'd0, 5, {16'h0, drp_data(7'h33)}, 1'b0);
    wait_done(200);

    // Read whose DRDY never arrives, then a good read keeps err set
    drp_resp_en = 1'b0;
    do_req(1'b0, 7'h22, 32'd0, 2 + P_DRDY_TMO, 32'd0, 1'b1);
    wait_done(300);
    check_val("rd_tmo_err", 32'(err), 32'd1);
    drp_resp_en = 1'b1;
    do_req(1'b0, 7'h41, 32'd0, 5, {16'h0, drp_data(7'h41)}, 1'b0);
    wait_done(200);
    check_val("err_sticky", 32'(err), 32'd1);

    // Reset clears err; write with LOCKED held low times out
    apply_reset();
    check_val("rst_clears_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    lock_en = 1'b0;
    @(posedge clk); #1;
    do_req(1'b1, 7'h09, 32'h00005A5A, 0, 32'd0, 1'b1);
    wait_done(600);
    check_val("lock_tmo_latency", 32'(rdy_cyc - rst_fall_cyc), 32'(P_LOCK_TMO));
    check_val("lock_tmo_err", 32'(err), 32'd1);
    lock_en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    do_req(1'b0, 7'h15, 32'd0, 5, {16'h0, drp_data(7'h15)}, 1'b0);
    wait_done(200);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Hard stop in case something above stops making progress.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmcm_drp_ctrl.md
# mmcm_drp_ctrl

Sequencer between the MMCM register-cache bus block and the MMCM/PLL primitive's DRP port. It accepts single-register read/write requests on the `cfg_*` handshake and performs the matching DRP transaction. Writes are wrapped in an MMCM reset plus lock-reacquire sequence. A single `cfg_rdy` pulse completes every request, including failed ones, so the upstream block never hangs.

## Interface
Parameters:
- `RST_HOLD`, 8: cycles `mmcm_rst` stays high after a write's DRDY; legal range is ≥4 (covers the locked synchronizer).
- `DRDY_TIMEOUT`, 64: cycles allowed from DEN to DRDY.
- `LOCK_TIMEOUT`, 65535: cycles allowed from `mmcm_rst` deassertion to a synchronized LOCKED; 16-bit counter.

Ports:
- `clk` in 1: DRP clock, the single clock domain.
- `rst_n` in 1: reset, synchronous and active-low.
- `cfg_ena` in 1: request strobe, sampled only in IDLE.
- `cfg_wen` in 1: 1 = write, 0 = read; qualified by `cfg_ena`.
- `cfg_addr` in 7: DRP register address.
- `cfg_wdata` in 32: write data; only [15:0] is used.
- `cfg_rdata` out 32: {16'h0, read data}; valid while `cfg_rdy` is high and held until the next read completes.
- `cfg_rdy` out 1: one-cycle completion pulse, exactly one per accepted request.
- `drp_den` out 1, `drp_dwe` out 1, `drp_daddr` out 7, `drp_di` out 16: DRP request outputs.
- `drp_do` in 16, `drp_drdy` in 1: DRP response inputs.
- `mmcm_rst` out 1: MMCM reset.
- `mmcm_locked` in 1: MMCM LOCKED; asynchronous to `clk`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: sticky flag for DRDY or lock timeout; cleared only by `rst_n`.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_RST, WR_REQ, WR_WAIT, RST_HOLD, LOCK_WAIT, DONE.
- IDLE:
  - `cfg_ena` & ~`cfg_wen` → RD_REQ.
  - `cfg_ena` & `cfg_wen` → WR_RST.
  - Latch `cfg_addr` and `cfg_wdata[15:0]` on acceptance.
- Read path:
  - RD_REQ: `drp_den`=1 for exactly one cycle, `drp_dwe`=0. Go to RD_WAIT.
  - RD_WAIT, on `drp_drdy`: register `drp_do` into `cfg_rdata`, go to DONE.
  - RD_WAIT, on timeout: `cfg_rdata`=0, set `err`, go to DONE.
- Write path:
  - WR_RST: `mmcm_rst`=1 for one cycle. Go to WR_REQ.
  - WR_REQ: `drp_den`=`drp_dwe`=1 for exactly one cycle, `drp_di` = latched data. Go to WR_WAIT.
  - WR_WAIT, on `drp_drdy` or timeout: go to RST_HOLD. A timeout also sets `err`.
  - RST_HOLD: count `RST_HOLD` cycles, then drop `mmcm_rst` and go to LOCK_WAIT.
  - LOCK_WAIT, on synchronized locked=1: go to DONE.
  - LOCK_WAIT, on `LOCK_TIMEOUT` expiry: set `err`, go to DONE.
- `mmcm_rst` is high from WR_RST through the end of RST_HOLD.
- DONE: `cfg_rdy`=1 for one cycle, then IDLE.
- `cfg_ena` outside IDLE is ignored; no queueing.
- `drp_drdy` outside RD_WAIT and WR_WAIT is ignored.
- `drp_daddr` and `drp_di` hold their latched values and are don't-care while `drp_den`=0.
- Timeout counters reset on every state entry and saturate; they do not wrap.

## Timing
- Reset values: every output is 0, including `cfg_rdata`, `mmcm_rst` and `err`. The state is IDLE.
- `rst_n` low at any point returns to IDLE in the next cycle:
  - `mmcm_rst` drops and no `cfg_rdy` is issued.
  - An in-flight DRP access is abandoned.
- All outputs are registered.
- Read latency: `cfg_ena` at cycle 0 → `drp_den` at cycle 1 → `drp_drdy` at cycle d ≥ 2 → `cfg_rdy` and `cfg_rdata` at cycle d+1.
- Read timeout: DRDY never arrives → `cfg_rdy` at cycle 2+`DRDY_TIMEOUT`.
- Write: `mmcm_rst` rises at cycle 1 and `drp_den`/`drp_dwe` at cycle 2. After DRDY, `mmcm_rst` falls `RST_HOLD` cycles later. `cfg_rdy` follows 1 cycle after the synchronized lock, which is 2 flops after `mmcm_locked`.
- `drp_drdy` arriving in the same cycle as a timeout expiry counts as success; `err` is not set.
- Back-to-back requests: the earliest next acceptance is the cycle after `cfg_rdy`.

## Structure
- Package `mmcm_drp_pkg` holds:
  - the state enum;
  - `DRP_AW`=7 and `DRP_DW`=16;
  - default timeout constants.
- Sub-module `sync_ff` is a 2-flop synchronizer for `mmcm_locked`. Its reset value is 0 and it uses `rst_n`.

## Test plan
- Read, DRP model DRDY after 3 cycles, `cfg_addr`=7'h14, `drp_do`=16'hA5C3 → `drp_den` exactly 1 cycle with `drp_daddr`=7'h14; `cfg_rdata`=32'h0000A5C3 with one `cfg_rdy` pulse; `err`=0.
- Write 7'h08 ← 32'hDEAD1234 with lock returning 20 cycles after reset release → `mmcm_rst` precedes `drp_den`; `drp_dwe`=1 and `drp_di`=16'h1234; `mmcm_rst` high ≥ `RST_HOLD`+1 cycles; exactly one `cfg_rdy` after the synchronized lock.
- Read with DRDY never asserted → `cfg_rdy` at cycle 2+`DRDY_TIMEOUT`, `cfg_rdata`=0, `err`=1 and stays 1 through subsequent good transfers.
- Write with LOCKED held low, `LOCK_TIMEOUT`=100 → `cfg_rdy` about 100 cycles after `mmcm_rst` falls; `err`=1.
- `cfg_ena` pulses while busy, plus 16 back-to-back reads → extra strobes ignored; exactly 16 `cfg_rdy` pulses.
- `rst_n` low during RST_HOLD → next cycle state is IDLE, `mmcm_rst`=0, no `cfg_rdy`; a following read works normally.
